// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: datapath width, FSM state
// encodings and the ALU select codes the control unit uses to route divides.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CALC    = 2'd1;
  localparam logic [1:0] FIX     = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [3:0] ALU_SEL_DIV = 4'b1001;
  localparam logic [3:0] ALU_SEL_REM = 4'b1010;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference or restore.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           dvd_bit,
  input  logic [WIDTH:0] dvs,
  output logic [WIDTH:0] rem_out,
  output logic           quo_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The partial remainder stays below the divisor, so the MSB of the
  // difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, dvs};
    quo_bit = ~diff[WIDTH+1];
    rem_out = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per clock.
// The FSM, iteration counter and sign fix-up live here; the step is div_step.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (quo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .quo_bit (step_bit)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    busy_d        = busy_q;
    done_d        = done_q;
    div_by_zero_d = div_by_zero_q;

    // Negating the most negative value wraps to itself, which read as an
    // unsigned magnitude is exactly 2^(WIDTH-1).
    dvd_mag = (signed_op && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dvs_mag = (signed_op && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          quo_d     = dvd_mag;
          rem_d     = '0;
          dvs_d     = {1'b0, dvs_mag};
          dvd_d     = dividend;
          neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_op & dividend[WIDTH-1];
          dbz_d     = (divisor == '0);
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
        end
        div_by_zero_d = dbz_q;
        busy_d        = 1'b0;
        done_d        = 1'b1;
        state_d       = DONE_ST;
      end
      DONE_ST: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      dvd_q         <= dvd_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;

endmodule
